// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bundle for the 4:1 round-robin arbiter.
//   I0..I3 : requester data          V : requester valid (bit i for Ii)
//   L      : requester last flags    R : requester ready (one-hot or zero)
//   O/OV/OL: registered output beat  ORDY : downstream ready
//   S      : select of beat in O     LOCK : arbiter is holding a packet grant
interface mux4_rr_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] I0;
    logic [WIDTH-1:0] I1;
    logic [WIDTH-1:0] I2;
    logic [WIDTH-1:0] I3;
    logic [3:0]       V;
    logic [3:0]       L;
    logic [3:0]       R;
    logic [WIDTH-1:0] O;
    logic             OV;
    logic             OL;
    logic             ORDY;
    logic [1:0]       S;
    logic             LOCK;

    // Arbiter side
    modport slave (
        input  I0, I1, I2, I3, V, L, ORDY,
        output R, O, OV, OL, S, LOCK
    );

    // Requesters plus downstream consumer
    modport master (
        output I0, I1, I2, I3, V, L, ORDY,
        input  R, O, OV, OL, S, LOCK
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter steering four valid/ready requesters through one 4:1
// word mux into a single registered output beat, with packet locking until
// the granted requester's LAST beat.
//   CLK         : rising-edge clock
//   ASYNCRESETN : asynchronous active-low reset
//   bus         : slave side of mux4_rr_arbiter_if (requesters, output beat,
//                 downstream ready, select and lock status)
module mux4_rr_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  ASYNCRESETN,
    mux4_rr_arbiter_if.slave      bus
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_q;
    logic [1:0]       p_q;
    logic [1:0]       s_q;
    logic [WIDTH-1:0] o_q;
    logic             ol_q;
    logic             ov_q;

    logic             load_c;
    logic             found_c;
    logic [1:0]       win_c;
    logic [1:0]       cand_c;
    logic [3:0]       r_c;
    logic [WIDTH-1:0] mux_c;

    // Winner search: locked owner only, otherwise rotate from P+1 to P
    always_comb begin
        load_c  = !ov_q || bus.ORDY;
        found_c = 1'b0;
        win_c   = 2'd0;
        cand_c  = 2'd0;
        r_c     = 4'b0000;
        if (state_q == ST_LOCKED) begin
            // s_q is the owner: it holds the select of the last granted beat
            found_c = bus.V[s_q];
            win_c   = s_q;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                cand_c = p_q + 2'(k);
                if (!found_c && bus.V[cand_c]) begin
                    found_c = 1'b1;
                    win_c   = cand_c;
                end
            end
        end
        // Reset gates R so no requester sees a handshake while held in reset
        if (ASYNCRESETN && load_c && found_c) begin
            r_c[win_c] = 1'b1;
        end
    end

    // Shared 4:1 data mux
    always_comb begin
        mux_c = bus.I0;
        case (win_c)
            2'd0:    mux_c = bus.I0;
            2'd1:    mux_c = bus.I1;
            2'd2:    mux_c = bus.I2;
            default: mux_c = bus.I3;
        endcase
    end

    // Output beat, pointer and lock state
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= ST_IDLE;
            p_q     <= 2'd3;
            s_q     <= 2'd0;
            o_q     <= '0;
            ol_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else if (load_c) begin
            if (found_c) begin
                o_q     <= mux_c;
                ol_q    <= bus.L[win_c];
                s_q     <= win_c;
                ov_q    <= 1'b1;
                p_q     <= win_c;
                state_q <= bus.L[win_c] ? ST_IDLE : ST_LOCKED;
            end else begin
                // Slot drained with nothing to replace it; data/select hold
                ov_q    <= 1'b0;
            end
        end
    end

    assign bus.R    = r_c;
    assign bus.O    = o_q;
    assign bus.OV   = ov_q;
    assign bus.OL   = ol_q;
    assign bus.S    = s_q;
    assign bus.LOCK = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din [4];
    logic [3:0] v_in;
    logic [3:0] l_in;
    logic       ordy_in;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mux4_rr_arbiter_if #(.WIDTH(8)) bus ();

    assign bus.I0   = din[0];
    assign bus.I1   = din[1];
    assign bus.I2   = din[2];
    assign bus.I3   = din[3];
    assign bus.V    = v_in;
    assign bus.L    = l_in;
    assign bus.ORDY = ordy_in;

    mux4_rr_arbiter #(.WIDTH(8)) dut (
        .CLK         (clk),
        .ASYNCRESETN (rst_n),
        .bus         (bus)
    );

    // Behavioural model: owner < 0 means unlocked
    int         m_p;
    int         m_owner;
    int         m_s;
    logic [7:0] m_o;
    bit         m_ol;
    bit         m_ov;

    function automatic int pick();
        int idx;
        if (m_ov && !ordy_in) return -1;
        if (m_owner >= 0) return v_in[m_owner] ? m_owner : -1;
        for (int k = 1; k <= 4; k++) begin
            idx = (m_p + k) % 4;
            if (v_in[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_r();
        int w;
        w = pick();
        if (!rst_n || w < 0) return 4'b0000;
        return 4'(1 << w);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int  w;
        bit  load;
        if (!rst_n) begin
            m_p = 3; m_owner = -1; m_s = 0; m_o = 8'h00; m_ol = 1'b0; m_ov = 1'b0;
        end else begin
            load = !m_ov || ordy_in;
            w    = pick();
            if (load) begin
                if (w >= 0) begin
                    m_o     = din[w];
                    m_ol    = l_in[w];
                    m_s     = w;
                    m_ov    = 1'b1;
                    m_p     = w;
                    m_owner = l_in[w] ? -1 : w;
                end else begin
                    m_ov = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("m_r",    32'(bus.R),    32'(exp_r()));
            chk("m_o",    32'(bus.O),    32'(m_o));
            chk("m_ov",   32'(bus.OV),   32'(m_ov));
            chk("m_ol",   32'(bus.OL),   32'(m_ol));
            chk("m_s",    32'(bus.S),    32'(m_s));
            chk("m_lock", 32'(bus.LOCK), 32'(m_owner >= 0));
        end
    end

    logic [7:0] seq [8];

    initial begin
        seq = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10, 8'h21, 8'h32, 8'h43};
        rst_n = 1'b0; v_in = 4'h0; l_in = 4'h0; ordy_in = 1'b0;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        repeat (2) @(posedge clk);
        #2;
        v_in = 4'hF; l_in = 4'hF; ordy_in = 1'b1;
        din[0] = 8'h10; din[1] = 8'h21; din[2] = 8'h32; din[3] = 8'h43;
        #1;
        chk("rst_r", 32'(bus.R), 32'h0);
        chk("rst_ov", 32'(bus.OV), 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1; chk_en = 1'b1;

        // First grant after reset goes to requester 0, then strict rotation
        @(negedge clk);
        chk("first_r", 32'(bus.R), 32'h1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_o", 32'(bus.O), 32'(seq[i]));
            chk("rr_ov", 32'(bus.OV), 32'h1);
        end

        // Mid-cycle asynchronous reset with V still all ones
        #1 rst_n = 1'b0;
        #1;
        chk("arst_o", 32'(bus.O), 32'h0);
        chk("arst_ov", 32'(bus.OV), 32'h0);
        chk("arst_s", 32'(bus.S), 32'h0);
        chk("arst_lock", 32'(bus.LOCK), 32'h0);
        chk("arst_r", 32'(bus.R), 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Packet lock: three beats from I0, then I1
        v_in = 4'b0011; l_in = 4'b0010; din[0] = 8'hA0; din[1] = 8'hB0;
        @(negedge clk);
        chk("pk_r0", 32'(bus.R), 32'h1);
        @(posedge clk); #2;
        din[0] = 8'hA1;
        @(negedge clk);
        chk("pk_o0", 32'(bus.O), 32'hA0);
        chk("pk_lock0", 32'(bus.LOCK), 32'h1);
        @(posedge clk); #2;
        din[0] = 8'hA2; l_in = 4'b0011;
        @(negedge clk);
        chk("pk_o1", 32'(bus.O), 32'hA1);
        chk("pk_lock1", 32'(bus.LOCK), 32'h1);
        chk("pk_r1", 32'(bus.R), 32'h1);
        @(negedge clk);
        chk("pk_o2", 32'(bus.O), 32'hA2);
        chk("pk_ol2", 32'(bus.OL), 32'h1);
        chk("pk_lock2", 32'(bus.LOCK), 32'h0);
        chk("pk_r2", 32'(bus.R), 32'h2);
        @(negedge clk);
        chk("pk_o3", 32'(bus.O), 32'hB0);
        chk("pk_s3", 32'(bus.S), 32'h1);

        // Backpressure on a stream from I2
        @(posedge clk); #2;
        v_in = 4'b0100; l_in = 4'b0100; din[2] = 8'hC0;
        @(negedge clk);
        chk("bp_r", 32'(bus.R), 32'h4);
        @(posedge clk); #2;
        ordy_in = 1'b0; din[2] = 8'hC1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_stall_r", 32'(bus.R), 32'h0);
            chk("bp_stall_o", 32'(bus.O), 32'hC0);
            chk("bp_stall_ov", 32'(bus.OV), 32'h1);
            chk("bp_stall_s", 32'(bus.S), 32'h2);
        end
        ordy_in = 1'b1;
        @(negedge clk);
        chk("bp_resume_o", 32'(bus.O), 32'hC1);
        chk("bp_resume_ov", 32'(bus.OV), 32'h1);

        // Idle: output valid drops, data and select retained
        v_in = 4'b0000;
        @(negedge clk);
        chk("idle_ov", 32'(bus.OV), 32'h0);
        chk("idle_o", 32'(bus.O), 32'hC1);
        chk("idle_s", 32'(bus.S), 32'h2);

        // Locked starvation: owner 1 silent while requester 3 waits
        v_in = 4'b0010; l_in = 4'b0000; din[1] = 8'hD0;
        @(negedge clk);
        chk("st_lock", 32'(bus.LOCK), 32'h1);
        chk("st_o", 32'(bus.O), 32'hD0);
        v_in = 4'b1000; l_in = 4'b1000; din[3] = 8'hE0;
        repeat (4) begin
            @(negedge clk);
            chk("st_r", 32'(bus.R), 32'h0);
            chk("st_ov", 32'(bus.OV), 32'h0);
            chk("st_hold", 32'(bus.LOCK), 32'h1);
        end
        v_in = 4'b1010; l_in = 4'b1010; din[1] = 8'hD1;
        @(negedge clk);
        chk("st_rel_o", 32'(bus.O), 32'hD1);
        chk("st_rel_lock", 32'(bus.LOCK), 32'h0);
        @(negedge clk);
        chk("st_next_o", 32'(bus.O), 32'hE0);
        chk("st_next_s", 32'(bus.S), 32'h3);

        // Randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk); #2;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
            v_in    = 4'($urandom_range(0, 15));
            l_in    = 4'($urandom_range(0, 15));
            ordy_in = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) din[i] = 8'($urandom_range(0, 255));
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
